// File: rtl/control_pkg.sv
// control_pkg: opcodes, state encoding, ctrl strobe indices and opcode classification
package control_pkg;
    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_NOP  = 5'b11000;
    localparam logic [4:0] OP_HALT = 5'b11001;

    localparam int PC_OUT    = 0;
    localparam int MAR_IN    = 1;
    localparam int INC_PC    = 2;
    localparam int Z_IN      = 3;
    localparam int PC_IN     = 4;
    localparam int MDR_IN    = 5;
    localparam int IR_IN     = 6;
    localparam int MDR_OUT   = 7;
    localparam int GRA       = 8;
    localparam int GRB       = 9;
    localparam int GRC       = 10;
    localparam int R_IN      = 11;
    localparam int R_OUT     = 12;
    localparam int BA_OUT    = 13;
    localparam int Y_IN      = 14;
    localparam int C_OUT     = 15;
    localparam int ZLOW_OUT  = 16;
    localparam int RAM_READ  = 17;
    localparam int RAM_WRITE = 18;
    localparam int MD_READ   = 19;
    localparam int CON_IN    = 20;

    // T0..T7 are consecutive so the sequencer advances by increment
    typedef enum logic [3:0] {
        ST_RESET = 4'd0, ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7, ST_HALT
    } state_e;

    typedef enum logic [1:0] {NX_STEP, NX_END, NX_HALT} nxt_e;

    typedef enum logic [3:0] {
        K_R, K_I, K_LD, K_LDI, K_ST, K_BR, K_JR, K_NOP, K_HALT, K_BAD
    } kind_e;

    function automatic logic [20:0] m(input int i);
        return 21'(1) << i;
    endfunction

    function automatic kind_e kind_of(input logic [4:0] op);
        return (op inside {OP_ADD, OP_SUB, OP_AND, OP_OR}) ? K_R :
               (op inside {OP_ADDI, OP_ANDI, OP_ORI})     ? K_I :
               (op == OP_LD)   ? K_LD   :
               (op == OP_LDI)  ? K_LDI  :
               (op == OP_ST)   ? K_ST   :
               (op == OP_BR)   ? K_BR   :
               (op == OP_JR)   ? K_JR   :
               (op == OP_NOP)  ? K_NOP  :
               (op == OP_HALT) ? K_HALT : K_BAD;
    endfunction
endpackage

// File: rtl/control_sequencer_if.sv
// control_sequencer_if: datapath <-> sequencer signals; master is the datapath side
interface control_sequencer_if;
    logic [31:0] ir;
    logic        con_ff;
    logic        stop;
    logic [20:0] ctrl;
    logic [4:0]  alu_op;
    logic        run;
    logic [3:0]  state_out;
    modport master (output ir, con_ff, stop, input ctrl, alu_op, run, state_out);
    modport slave  (input ir, con_ff, stop, output ctrl, alu_op, run, state_out);
endinterface

// File: rtl/control_decode.sv
// control_decode: Moore strobe decode and next-state class from (state, opcode, con_ff)
module control_decode
    import control_pkg::*;
#(
    parameter bit HALT_ON_ILLEGAL = 1'b0
) (
    input  state_e      state_i,
    input  logic [4:0]  opcode_i,
    input  logic        con_ff_i,
    output logic [20:0] ctrl_o,
    output logic [4:0]  alu_op_o,
    output nxt_e        nxt_o
);
    kind_e k;

    assign k = (kind_of(opcode_i) == K_BAD) ? (HALT_ON_ILLEGAL ? K_HALT : K_NOP) : kind_of(opcode_i);

    always_comb begin
        ctrl_o   = '0;
        alu_op_o = '0;
        nxt_o    = NX_STEP;
        case (state_i)
            ST_T0: ctrl_o = m(PC_OUT) | m(MAR_IN) | m(INC_PC) | m(Z_IN);
            ST_T1: ctrl_o = m(ZLOW_OUT) | m(PC_IN) | m(RAM_READ) | m(MD_READ) | m(MDR_IN);
            ST_T2: begin
                ctrl_o = m(MDR_OUT) | m(IR_IN);
                nxt_o  = (k == K_HALT) ? NX_HALT : (k == K_NOP) ? NX_END : NX_STEP;
            end
            ST_T3: case (k)
                K_R, K_I:           ctrl_o = m(GRB) | m(R_OUT) | m(Y_IN);
                K_LD, K_LDI, K_ST:  ctrl_o = m(GRB) | m(BA_OUT) | m(Y_IN);
                K_BR:               ctrl_o = m(GRA) | m(R_OUT) | m(CON_IN);
                K_JR: begin
                    ctrl_o = m(GRA) | m(R_OUT) | m(PC_IN);
                    nxt_o  = NX_END;
                end
                default:            nxt_o = NX_END;
            endcase
            ST_T4: case (k)
                K_R: begin
                    ctrl_o   = m(GRC) | m(R_OUT) | m(Z_IN);
                    alu_op_o = opcode_i;
                end
                K_I: begin
                    ctrl_o   = m(C_OUT) | m(Z_IN);
                    alu_op_o = opcode_i;
                end
                K_LD, K_LDI, K_ST: begin
                    ctrl_o   = m(C_OUT) | m(Z_IN);
                    alu_op_o = OP_ADD;
                end
                K_BR:               ctrl_o = m(PC_OUT) | m(Y_IN);
                default:            nxt_o = NX_END;
            endcase
            ST_T5: case (k)
                K_R, K_I, K_LDI: begin
                    ctrl_o = m(ZLOW_OUT) | m(GRA) | m(R_IN);
                    nxt_o  = NX_END;
                end
                K_LD, K_ST:         ctrl_o = m(ZLOW_OUT) | m(MAR_IN);
                K_BR: begin
                    ctrl_o   = m(C_OUT) | m(Z_IN);
                    alu_op_o = OP_ADD;
                end
                default:            nxt_o = NX_END;
            endcase
            ST_T6: case (k)
                K_LD:               ctrl_o = m(RAM_READ) | m(MD_READ) | m(MDR_IN);
                K_ST:               ctrl_o = m(GRA) | m(R_OUT) | m(MDR_IN);
                K_BR: begin
                    ctrl_o = m(ZLOW_OUT) | (con_ff_i ? m(PC_IN) : '0);
                    nxt_o  = NX_END;
                end
                default:            nxt_o = NX_END;
            endcase
            ST_T7: begin
                ctrl_o = (k == K_LD) ? (m(MDR_OUT) | m(GRA) | m(R_IN)) :
                         (k == K_ST) ? m(RAM_WRITE) : '0;
                nxt_o  = NX_END;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: instruction step sequencer; state register plus control_decode
module control_sequencer
    import control_pkg::*;
#(
    parameter bit HALT_ON_ILLEGAL = 1'b0
) (
    input logic                clock,
    input logic                clear,
    control_sequencer_if.slave bus
);
    state_e      state_q, state_d;
    nxt_e        nxt;
    logic [20:0] ctrl;
    logic [4:0]  alu_op;

    control_decode #(.HALT_ON_ILLEGAL(HALT_ON_ILLEGAL)) u_decode (
        .state_i  (state_q),
        .opcode_i (bus.ir[31:27]),
        .con_ff_i (bus.con_ff),
        .ctrl_o   (ctrl),
        .alu_op_o (alu_op),
        .nxt_o    (nxt)
    );

    // stop only matters at an instruction boundary, so in-flight steps always finish
    always_comb begin
        state_d = (state_q == ST_RESET) ? ST_T0 :
                  (state_q == ST_HALT)  ? ST_HALT :
                  (nxt == NX_HALT)      ? ST_HALT :
                  (nxt == NX_END)       ? (bus.stop ? ST_HALT : ST_T0) :
                  state_e'(state_q + 4'd1);
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) state_q <= ST_RESET;
        else        state_q <= state_d;
    end

    assign bus.ctrl      = ctrl;
    assign bus.alu_op    = alu_op;
    assign bus.run       = (state_q != ST_RESET) && (state_q != ST_HALT);
    assign bus.state_out = state_q;
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed and randomized checks against a step-table reference model
module tb_control_sequencer;
    import control_pkg::*;

    logic clock = 1'b0;
    logic clear = 1'b0;
    int   total = 0;
    int   passed = 0;

    always #5 clock = ~clock;

    control_sequencer_if bus0();
    control_sequencer_if bus1();

    assign bus1.ir     = bus0.ir;
    assign bus1.con_ff = bus0.con_ff;
    assign bus1.stop   = bus0.stop;

    control_sequencer dut0 (.clock(clock), .clear(clear), .bus(bus0.slave));
    control_sequencer #(.HALT_ON_ILLEGAL(1'b1)) dut1 (.clock(clock), .clear(clear), .bus(bus1.slave));

    typedef struct {
        logic [20:0] c;
        logic [4:0]  a;
        bit          ac;
    } step_t;

    step_t q[$];

    function automatic logic [20:0] sb(input int i);
        return 21'(1) << i;
    endfunction

    function automatic void put(input logic [20:0] c, input logic [4:0] a = 5'd0, input bit ac = 1'b0);
        q.push_back('{c, a, ac});
    endfunction

    // Expected strobes per step, built from the instruction table; undefined opcodes act as nop
    function automatic void build(input logic [4:0] op, input bit con, output bit halts);
        bit r  = op inside {OP_ADD, OP_SUB, OP_AND, OP_OR};
        bit im = op inside {OP_ADDI, OP_ANDI, OP_ORI};
        q.delete();
        halts = (op == OP_HALT);
        put(sb(PC_OUT) | sb(MAR_IN) | sb(INC_PC) | sb(Z_IN));
        put(sb(ZLOW_OUT) | sb(PC_IN) | sb(RAM_READ) | sb(MD_READ) | sb(MDR_IN));
        put(sb(MDR_OUT) | sb(IR_IN));
        if (r || im) begin
            put(sb(GRB) | sb(R_OUT) | sb(Y_IN));
            put(r ? (sb(GRC) | sb(R_OUT) | sb(Z_IN)) : (sb(C_OUT) | sb(Z_IN)), op, 1'b1);
            put(sb(ZLOW_OUT) | sb(GRA) | sb(R_IN));
        end else if (op inside {OP_LD, OP_LDI, OP_ST}) begin
            put(sb(GRB) | sb(BA_OUT) | sb(Y_IN));
            put(sb(C_OUT) | sb(Z_IN), 5'b00011, 1'b1);
            if (op == OP_LDI) put(sb(ZLOW_OUT) | sb(GRA) | sb(R_IN));
            else begin
                put(sb(ZLOW_OUT) | sb(MAR_IN));
                put(op == OP_LD ? (sb(RAM_READ) | sb(MD_READ) | sb(MDR_IN)) : (sb(GRA) | sb(R_OUT) | sb(MDR_IN)));
                put(op == OP_LD ? (sb(MDR_OUT) | sb(GRA) | sb(R_IN)) : sb(RAM_WRITE));
            end
        end else if (op == OP_BR) begin
            put(sb(GRA) | sb(R_OUT) | sb(CON_IN));
            put(sb(PC_OUT) | sb(Y_IN));
            put(sb(C_OUT) | sb(Z_IN), 5'b00011, 1'b1);
            put(sb(ZLOW_OUT) | (con ? sb(PC_IN) : 21'd0));
        end else if (op == OP_JR) begin
            put(sb(GRA) | sb(R_OUT) | sb(PC_IN));
        end
    endfunction

    task automatic do_clear(input string nm);
        clear = 1'b0;
        #2;
        total++;
        if ({bus0.state_out, bus0.ctrl, bus0.run, bus0.alu_op} !== {4'(ST_RESET), 21'd0, 1'b0, 5'd0})
            $display("FAIL %s clear-held: state=%0d ctrl=%h run=%b alu=%b, required state=%0d ctrl=0 run=0 alu=0",
                     nm, bus0.state_out, bus0.ctrl, bus0.run, bus0.alu_op, ST_RESET);
        else passed++;
        clear = 1'b1;
        @(posedge clock); #1;
        total++;
        if ({bus0.state_out, bus0.run} !== {4'(ST_T0), 1'b1})
            $display("FAIL %s after-clear: state=%0d run=%b, required state=%0d run=1", nm, bus0.state_out, bus0.run, ST_T0);
        else passed++;
    endtask

    // Entered with dut0 sampled in T0; returns with dut0 sampled in T0 again
    task automatic run_instr(input logic [31:0] v, input bit con, input bit stop3, input string nm);
        bit halts;
        logic [3:0] es;
        bus0.ir = v;
        bus0.con_ff = con;
        build(v[31:27], con, halts);
        foreach (q[k]) begin
            if (stop3 && k == 3) bus0.stop = 1'b1;
            total++;
            if ({bus0.state_out, bus0.ctrl, bus0.run} !== {4'(ST_T0) + 4'(k), q[k].c, 1'b1})
                $display("FAIL %s step %0d: state=%0d ctrl=%h run=%b, required state=%0d ctrl=%h run=1",
                         nm, k, bus0.state_out, bus0.ctrl, bus0.run, 4'(ST_T0) + 4'(k), q[k].c);
            else passed++;
            if (q[k].ac) begin
                total++;
                if (bus0.alu_op !== q[k].a)
                    $display("FAIL %s alu_op step %0d: got %b, required %b", nm, k, bus0.alu_op, q[k].a);
                else passed++;
            end
            @(posedge clock); #1;
        end
        bus0.stop = 1'b0;
        es = (halts || stop3) ? 4'(ST_HALT) : 4'(ST_T0);
        total++;
        if (bus0.state_out !== es)
            $display("FAIL %s end state after %0d steps: got %0d, required %0d", nm, q.size(), bus0.state_out, es);
        else passed++;
        if (es == 4'(ST_HALT)) begin
            repeat (10) begin
                total++;
                if ({bus0.state_out, bus0.ctrl, bus0.run, bus0.alu_op} !== {4'(ST_HALT), 21'd0, 1'b0, 5'd0})
                    $display("FAIL %s halt-hold: state=%0d ctrl=%h run=%b alu=%b, required state=%0d ctrl=0 run=0 alu=0",
                             nm, bus0.state_out, bus0.ctrl, bus0.run, bus0.alu_op, ST_HALT);
                else passed++;
                @(posedge clock); #1;
            end
            do_clear(nm);
        end
    endtask

    task automatic test_reset();
        #3;
        total++;
        if ({bus0.state_out, bus0.ctrl, bus0.run, bus0.alu_op} !== {4'(ST_RESET), 21'd0, 1'b0, 5'd0})
            $display("FAIL reset: state=%0d ctrl=%h run=%b alu=%b, required state=%0d ctrl=0 run=0 alu=0",
                     bus0.state_out, bus0.ctrl, bus0.run, bus0.alu_op, ST_RESET);
        else passed++;
        @(posedge clock); #1;
        total++;
        if ({bus0.state_out, bus0.run} !== {4'(ST_RESET), 1'b0})
            $display("FAIL reset-edge: state=%0d run=%b, required state=%0d run=0", bus0.state_out, bus0.run, ST_RESET);
        else passed++;
        clear = 1'b1;
        @(posedge clock); #1;
        total++;
        if ({bus0.state_out, bus0.run} !== {4'(ST_T0), 1'b1})
            $display("FAIL reset-release: state=%0d run=%b, required state=%0d run=1", bus0.state_out, bus0.run, ST_T0);
        else passed++;
    endtask

    task automatic test_directed();
        run_instr(32'h6918000D, 1'b0, 1'b0, "andi");
        run_instr(32'h00800055, 1'b0, 1'b0, "ld");
        run_instr(32'h10800055, 1'b1, 1'b0, "st");
        run_instr(32'h90000000, 1'b0, 1'b0, "br-nottaken");
        run_instr(32'h90000000, 1'b1, 1'b0, "br-taken");
        run_instr(32'hA0800000, 1'b0, 1'b0, "jr");
        run_instr(32'hC0000000, 1'b0, 1'b0, "nop");
    endtask

    task automatic test_halt();
        run_instr(32'hC8000000, 1'b0, 1'b0, "halt");
    endtask

    task automatic test_clear_mid();
        bus0.ir = {OP_ADD, 27'h0123456};
        bus0.con_ff = 1'b0;
        repeat (4) begin
            @(posedge clock); #1;
        end
        total++;
        if ({bus0.state_out, bus0.ctrl} !== {4'(ST_T4), sb(GRC) | sb(R_OUT) | sb(Z_IN)})
            $display("FAIL clear-mid setup: state=%0d ctrl=%h, required state=%0d ctrl=%h",
                     bus0.state_out, bus0.ctrl, ST_T4, sb(GRC) | sb(R_OUT) | sb(Z_IN));
        else passed++;
        #2 clear = 1'b0;
        #1;
        total++;
        if ({bus0.state_out, bus0.ctrl, bus0.run, bus0.alu_op} !== {4'(ST_RESET), 21'd0, 1'b0, 5'd0})
            $display("FAIL clear-mid async: state=%0d ctrl=%h run=%b alu=%b, required state=%0d ctrl=0 run=0 alu=0",
                     bus0.state_out, bus0.ctrl, bus0.run, bus0.alu_op, ST_RESET);
        else passed++;
        #1 clear = 1'b1;
        @(posedge clock); #1;
        total++;
        if (bus0.state_out !== 4'(ST_T0))
            $display("FAIL clear-mid release: state=%0d, required %0d", bus0.state_out, ST_T0);
        else passed++;
    endtask

    task automatic test_stop();
        run_instr({OP_ADD, 27'h0000123}, 1'b0, 1'b1, "stop-add");
        run_instr({OP_LD, 27'h0000456}, 1'b0, 1'b1, "stop-ld");
    endtask

    task automatic test_illegal();
        do_clear("illegal-pre");
        bus0.ir = {5'b11111, 27'h0};
        repeat (3) begin
            @(posedge clock); #1;
        end
        total++;
        if (bus0.state_out !== 4'(ST_T0))
            $display("FAIL illegal-as-nop: state=%0d, required %0d", bus0.state_out, ST_T0);
        else passed++;
        total++;
        if ({bus1.state_out, bus1.ctrl, bus1.run} !== {4'(ST_HALT), 21'd0, 1'b0})
            $display("FAIL illegal-as-halt: state=%0d ctrl=%h run=%b, required state=%0d ctrl=0 run=0",
                     bus1.state_out, bus1.ctrl, bus1.run, ST_HALT);
        else passed++;
        do_clear("illegal-post");
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            logic [4:0] op;
            op = 5'($urandom_range(0, 31));
            run_instr({op, 27'($urandom)}, 1'($urandom_range(0, 1)), 1'b0, "random");
        end
    endtask

    initial begin
        bus0.ir = '0;
        bus0.con_ff = 1'b0;
        bus0.stop = 1'b0;
        test_reset();
        test_directed();
        test_halt();
        test_clear_mid();
        test_stop();
        test_illegal();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d done", passed, total);
        $fatal(1);
    end
endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameter: HALT_ON_ILLEGAL, default 0, 1 = undefined opcode enters HALT; 0 = undefined opcode is treated as nop.
REQ-002 Port: clock  input  1  system clock; all state updates on rising edge.
REQ-003 Port: clear  input  1  reset, asynchronous, active-low.
REQ-004 Port: ir  input  32  datapath instruction register; opcode = ir[31:27].
REQ-005 Port: con_ff  input  1  datapath branch-condition flop output.
REQ-006 Port: stop  input  1  level request to halt at the next instruction boundary.
REQ-007 Port: ctrl  output  21  datapath control strobes, bit map per REQ-030.
REQ-008 Port: alu_op  output  5  ALU operation select, valid whenever ctrl.Zin=1.
REQ-009 Port: run  output  1  high when not in RESET_ST or HALT.
REQ-010 Port: state_out  output  4  current state encoding, for debug.

Function
REQ-011 States: RESET_ST, T0..T7, HALT. Outputs are Moore-decoded from state and ir. Unlisted strobes are 0.
REQ-012 RESET_ST -> T0 on the first clock after clear deasserts.
REQ-013 Fetch: T0 = PCout, MARin, IncPC, Zin. T1 = Zlowout, PCin, ram_read, MD_read, MDRin. T2 = MDRout, IRin.
REQ-014 Opcodes: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 00101, or 00110, addi 01100, andi 01101, ori 01110, br 10010, jr 10100, nop 11000, halt 11001. All others are undefined.
REQ-015 R-type (add/sub/and/or): T3 = Grb, Rout, Yin. T4 = Grc, Rout, Zin, alu_op=opcode. T5 = Zlowout, Gra, Rin. Then T0.
REQ-016 I-type ALU (addi/andi/ori): T3 = Grb, Rout, Yin. T4 = Cout, Zin, alu_op=opcode. T5 = Zlowout, Gra, Rin. Then T0.
REQ-017 ld/ldi/st: T3 = Grb, BAout, Yin. T4 = Cout, Zin, alu_op=00011.
REQ-018 ldi: T5 = Zlowout, Gra, Rin. Then T0.
REQ-019 ld: T5 = Zlowout, MARin. T6 = ram_read, MD_read, MDRin. T7 = MDRout, Gra, Rin. Then T0.
REQ-020 st: T5 = Zlowout, MARin. T6 = Gra, Rout, MDRin. T7 = ram_write. Then T0.
REQ-021 br: T3 = Gra, Rout, CONin. T4 = PCout, Yin. T5 = Cout, Zin, alu_op=00011. T6 = Zlowout, plus PCin only if con_ff=1 during T6. Then T0.
REQ-022 jr: T3 = Gra, Rout, PCin. Then T0.
REQ-023 nop: T2 -> T0.
REQ-024 halt: T2 -> HALT. HALT holds all ctrl=0 until clear.
REQ-025 Undefined opcode: handled as nop when HALT_ON_ILLEGAL=0; handled as halt when HALT_ON_ILLEGAL=1.
REQ-026 Cycle counts, T0 through last step: nop 3, jr 4, R/I-type 6, ldi 6, br 7, ld 8, st 8.
REQ-027 stop is sampled only on the transition that would enter T0. If stop=1, the sequencer enters HALT instead. An in-flight instruction always completes.
REQ-028 run=0 in RESET_ST and HALT; run=1 otherwise.

Reset
REQ-029 clear=0 immediately (asynchronously) forces state RESET_ST, ctrl=0, alu_op=0, run=0, state_out=RESET_ST, from any state including mid-instruction. No strobe survives reset.

Structure
REQ-030 Shared package control_pkg holds:
- opcode constants;
- state encoding;
- ctrl bit indices 0..20 in this order: PCout, MARin, IncPC, Zin, PCin, MDRin, IRin, MDRout, Gra, Grb, Grc, Rin, Rout, BAout, Yin, Cout, Zlowout, ram_read, ram_write, MD_read, CONin.
REQ-031 One sub-module, control_decode, is combinational: (state, opcode, con_ff) -> (ctrl, alu_op, next-state class). The state register stays in control_sequencer.

Verification
REQ-032 andi ir=0x6918000D -> T3 ctrl={Grb,Rout,Yin}; T4 {Cout,Zin} with alu_op=01101; T5 {Zlowout,Gra,Rin}; T0 again 6 cycles after the prior T0.
REQ-033 ld ir=0x00800055 -> T5 {Zlowout,MARin}; T6 {ram_read,MD_read,MDRin}; T7 {MDRout,Gra,Rin}; 8-cycle instruction.
REQ-034 br ir=0x90000000: con_ff=0 -> T6 ctrl={Zlowout} only; con_ff=1 -> T6 {Zlowout,PCin}.
REQ-035 halt ir=0xC8000000 -> after T2, state HALT, run=0, ctrl=0 for 10+ cycles; clear pulse then returns to T0.
REQ-036 clear=0 asserted mid-T4 of add (no clock edge) -> ctrl=0 and run=0 within the same time step; the first edge after release gives state T0.
REQ-037 stop=1 raised during T3 of add -> T5 completes normally, next state HALT, no T0 strobes issued.
